// File: rtl/cpu_control_unit_if.sv
// Fetch-side <-> control-unit bus: instruction word, IN handshake, fetch controls and output port.
interface cpu_control_unit_if #(
    parameter int INSTRUCTION_LEN = 10,
    parameter int DATA_LEN        = 8
);
    logic [INSTRUCTION_LEN:0] IR;
    logic                     Enter;
    logic [DATA_LEN-1:0]      Input;
    logic                     IRload;
    logic                     PClocd;
    logic                     Jmux;
    logic [DATA_LEN-1:0]      Output;
    logic                     OutValid;
    logic                     Halt;
    logic [2:0]               State;

    modport master (
        output IR, Enter, Input,
        input  IRload, PClocd, Jmux, Output, OutValid, Halt, State
    );

    modport slave (
        input  IR, Enter, Input,
        output IRload, PClocd, Jmux, Output, OutValid, Halt, State
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Moore controller + 8-bit accumulator behind the fetch stage.
// CONTROL_STEP_EN adds a Step input that gates S_START -> S_FETCH (single-step mode).
module cpu_control_unit #(
    parameter int ADDR_LEN        = 4,
    parameter int INSTRUCTION_LEN = 10,
    parameter int DATA_LEN        = 8
) (
    input  logic Clock,
    input  logic Reset,
`ifdef CONTROL_STEP_EN
    input  logic Step,
`endif
    cpu_control_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_START  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_INWAIT = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_IN   = 3'b001;
    localparam logic [2:0] OP_OUT  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t              state;
    logic [DATA_LEN-1:0] acc;
    logic [DATA_LEN-1:0] out_q;
    logic                out_vld;
    logic [2:0]          op;
    logic                take_jump;

    // Jump target and spare bits are consumed by the fetch stage, not here.
    logic unused_ir;
    assign unused_ir = ^{bus.IR[INSTRUCTION_LEN], bus.IR[INSTRUCTION_LEN-4:0]};

    assign op        = bus.IR[INSTRUCTION_LEN-1 -: 3];
    assign take_jump = (op == OP_JMP) || ((op == OP_JNZ) && (acc != '0));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_START;
            acc     <= '0;
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= 1'b0;
            case (state)
                S_START: begin
`ifdef CONTROL_STEP_EN
                    if (Step) state <= S_FETCH;
`else
                    state <= S_FETCH;
`endif
                end
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_IN:   state <= S_INWAIT;
                        OP_HALT: state <= S_HALT;
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (op)
                        OP_OUT: begin
                            out_q   <= acc;
                            out_vld <= 1'b1;
                        end
                        OP_DEC:  acc <= acc - DATA_LEN'(1);
                        OP_INC:  acc <= acc + DATA_LEN'(1);
                        OP_NOP, OP_IN, OP_JMP, OP_JNZ, OP_HALT: ;
                        default: ;
                    endcase
                    state <= S_START;
                end
                S_INWAIT: begin
                    if (bus.Enter) begin
                        acc   <= bus.Input;
                        state <= S_START;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_START;
            endcase
        end
    end

    // Fetch controls follow the state register directly so reset takes effect immediately.
    always_comb begin
        bus.IRload = 1'b0;
        bus.PClocd = 1'b0;
        bus.Jmux   = 1'b1;
        bus.Halt   = 1'b0;
        case (state)
            S_FETCH: begin
                bus.IRload = 1'b1;
                bus.PClocd = 1'b1;
            end
            S_EXEC: begin
                if (take_jump) begin
                    bus.PClocd = 1'b1;
                    bus.Jmux   = 1'b0;
                end
            end
            S_HALT:  bus.Halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.State    = state;
    assign bus.Output   = out_q;
    assign bus.OutValid = out_vld;
endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized bench for cpu_control_unit against an instruction-level accumulator model.
module tb_cpu_control_unit;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_IN   = 3'b001;
    localparam logic [2:0] OP_OUT  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_JNZ  = 3'b101;
    localparam logic [2:0] OP_INC  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
`ifdef CONTROL_STEP_EN
    logic Step = 1'b0;
`endif

    cpu_control_unit_if #(.INSTRUCTION_LEN(10), .DATA_LEN(8)) bus ();

    cpu_control_unit #(.ADDR_LEN(4), .INSTRUCTION_LEN(10), .DATA_LEN(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
`ifdef CONTROL_STEP_EN
        .Step  (Step),
`endif
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural accumulator, output register, pending OutValid.
    logic [7:0] m_a   = 8'h00;
    logic [7:0] m_out = 8'h00;
    logic       m_ov  = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge Clock);
    endtask

    task automatic leave_start;
`ifdef CONTROL_STEP_EN
        int k;
        k = $urandom_range(0, 3);
        Step = 1'b0;
        for (int i = 0; i < k; i++) begin
            tick();
            chk("step_park_state", bus.State, 0);
            chk("step_park_irload", bus.IRload, 0);
            chk("step_park_ov", bus.OutValid, 0);
        end
        Step = 1'b1;
        tick();
        Step = 1'b0;
`else
        tick();
`endif
    endtask

    task automatic do_reset;
        #2 Reset = 1'b0;
        #1;
        chk("rst_state", bus.State, 0);
        chk("rst_irload", bus.IRload, 0);
        chk("rst_pclocd", bus.PClocd, 0);
        chk("rst_jmux", bus.Jmux, 1);
        chk("rst_halt", bus.Halt, 0);
        chk("rst_output", bus.Output, 0);
        chk("rst_outvalid", bus.OutValid, 0);
        for (int i = 0; i < 3; i++) begin
            bus.Enter = 1'($urandom);
            tick();
            chk("rst_hold_state", bus.State, 0);
        end
        bus.Enter = 1'b0;
        Reset = 1'b1;
        m_a   = 8'h00;
        m_out = 8'h00;
        m_ov  = 1'b0;
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [3:0] tgt,
                             input int wait_n, input logic [7:0] inval, input bit rst_in_wait);
        bit jump;
        chk("start_state", bus.State, 0);
        chk("start_irload", bus.IRload, 0);
        chk("start_pclocd", bus.PClocd, 0);
        chk("start_jmux", bus.Jmux, 1);
        chk("start_halt", bus.Halt, 0);
        chk("outvalid", bus.OutValid, int'(m_ov));
        chk("output", bus.Output, int'(m_out));
        bus.IR    = {1'($urandom), op, 3'($urandom), tgt};
        bus.Enter = 1'($urandom);
        bus.Input = 8'($urandom);
        leave_start();
        m_ov = 1'b0;
        chk("fetch_state", bus.State, 1);
        chk("fetch_irload", bus.IRload, 1);
        chk("fetch_pclocd", bus.PClocd, 1);
        chk("fetch_jmux", bus.Jmux, 1);
        chk("fetch_ov", bus.OutValid, 0);
        bus.Enter = 1'($urandom);
        tick();
        chk("decode_state", bus.State, 2);
        chk("decode_ctl", {bus.IRload, bus.PClocd, bus.Jmux}, 3'b001);
        if (op == OP_IN) begin
            bus.Enter = 1'b0;
            tick();
            if (rst_in_wait) begin
                chk("inwait_state", bus.State, 4);
                do_reset();
                return;
            end
            for (int i = 0; i < wait_n; i++) begin
                chk("inwait_state", bus.State, 4);
                bus.Enter = 1'b0;
                bus.Input = 8'($urandom);
                tick();
            end
            chk("inwait_state", bus.State, 4);
            bus.Enter = 1'b1;
            bus.Input = inval;
            tick();
            bus.Enter = 1'b0;
            m_a = inval;
        end else if (op == OP_HALT) begin
            bus.Enter = 1'($urandom);
            tick();
            for (int i = 0; i < 8; i++) begin
                chk("halt_state", bus.State, 5);
                chk("halt_flag", bus.Halt, 1);
                chk("halt_ctl", {bus.IRload, bus.PClocd, bus.Jmux}, 3'b001);
                bus.IR    = 11'($urandom);
                bus.Enter = 1'($urandom);
                bus.Input = 8'($urandom);
                tick();
            end
        end else begin
            bus.Enter = 1'($urandom);
            tick();
            jump = (op == OP_JMP) || (op == OP_JNZ && m_a != 8'h00);
            chk("exec_state", bus.State, 3);
            chk("exec_irload", bus.IRload, 0);
            chk("exec_pclocd", bus.PClocd, int'(jump));
            chk("exec_jmux", bus.Jmux, int'(!jump));
            bus.Enter = 1'($urandom);
            tick();
            case (op)
                OP_DEC: m_a = m_a - 8'd1;
                OP_INC: m_a = m_a + 8'd1;
                OP_OUT: begin m_out = m_a; m_ov = 1'b1; end
                default: ;
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] op;
        bus.IR    = '0;
        bus.Enter = 1'b0;
        bus.Input = '0;
        tick();
        tick();
        chk("init_state", bus.State, 0);
        chk("init_jmux", bus.Jmux, 1);
        chk("init_output", bus.Output, 0);
        Reset = 1'b1;

        // IN with a long Enter wait, then OUT the captured value.
        run_instr(OP_IN,  4'h0, 5, 8'h5A, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_NOP, 4'h0, 0, 8'h00, 1'b0);
        // Wrap-around at both ends.
        run_instr(OP_IN,  4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_DEC, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_INC, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);
        // Branches.
        run_instr(OP_IN,  4'h0, 1, 8'h03, 1'b0);
        run_instr(OP_JNZ, 4'h9, 0, 8'h00, 1'b0);
        run_instr(OP_IN,  4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_JNZ, 4'h9, 0, 8'h00, 1'b0);
        run_instr(OP_JMP, 4'hF, 0, 8'h00, 1'b0);
        // Reset in the middle of an IN wait, then prove A was cleared.
        run_instr(OP_IN,  4'h0, 0, 8'hC3, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_IN,  4'h0, 0, 8'h00, 1'b1);
        run_instr(OP_JNZ, 4'h2, 0, 8'h00, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 6));
            run_instr(op, 4'($urandom), $urandom_range(0, 3), 8'($urandom), 1'b0);
        end

        run_instr(OP_INC,  4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_HALT, 4'h0, 0, 8'h00, 1'b0);
        do_reset();
        run_instr(OP_INC, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_OUT, 4'h0, 0, 8'h00, 1'b0);
        run_instr(OP_NOP, 4'h0, 0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
